// File: rtl/serial_add_scheduler_pkg.sv
// Shared types and defaults for the two-requester bit-serial adder scheduler.
package serial_add_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_add_scheduler_serial_fa_bit.sv
// One-bit full adder with a registered carry that can be loaded, cleared or advanced.
module serial_fa_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic cin_i,
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  logic carry_q, carry_d;

  assign s_o = a_i ^ b_i ^ carry_q;
  assign c_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

  always_comb begin
    carry_d = carry_q;
    if (clr_i)       carry_d = 1'b0;
    else if (load_i) carry_d = cin_i;
    else if (en_i)   carry_d = c_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial adder between two requesters.
module serial_add_scheduler
  import serial_add_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q, id_q;
  logic             fa_load, fa_en, fa_clr, fa_s, fa_c;
  logic             last_shift;

  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  serial_fa_bit u_fa (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (fa_load),
    .en_i   (fa_en),
    .clr_i  (fa_clr),
    .cin_i  (win_q ? cin1 : cin0),
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .s_o    (fa_s),
    .c_o    (fa_c)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fa_load = 1'b0;
    fa_en   = 1'b0;
    fa_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // With both requesting, the one not served last wins.
          win_d   = (req == 2'b11) ? ~last_q : req[1];
          last_d  = win_d;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        fa_load = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        fa_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (last_shift) state_d = DONE;
      end
      DONE: begin
        fa_clr  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (last_shift) begin
        sum_q  <= {fa_s, a_q[WIDTH-1:1]};
        cout_q <= fa_c;
        id_q   <= win_q;
      end
    end
  end

  // The a shift register doubles as the result accumulator: sum bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      a_q <= win_q ? a1 : a0;
      b_q <= win_q ? b1 : b0;
    end else if (state_q == SHIFT) begin
      a_q <= {fa_s, a_q[WIDTH-1:1]};
      b_q <= {1'b0, b_q[WIDTH-1:1]};
    end
  end

  assign gnt     = ((state_q == LOAD) || (state_q == SHIFT)) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler at WIDTH=4 and WIDTH=8.
module tb_serial_add_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] a0, b0, a1, b1;
  logic       cin0, cin1;
  logic [1:0] gnt;
  logic       busy, done, done_id, cout;
  logic [3:0] sum;

  logic [1:0] req8;
  logic [7:0] a0_8, b0_8, a1_8, b1_8;
  logic       cin0_8, cin1_8;
  logic [1:0] gnt8;
  logic       busy8, done8, done_id8, cout8;
  logic [7:0] sum8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_add_scheduler #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .sum(sum), .cout(cout)
  );

  serial_add_scheduler #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8),
    .a0(a0_8), .b0(b0_8), .cin0(cin0_8), .a1(a1_8), .b1(b1_8), .cin1(cin1_8),
    .gnt(gnt8), .busy(busy8), .done(done8), .done_id(done_id8), .sum(sum8), .cout(cout8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency is counted inclusive of the IDLE cycle in which req is first sampled.
  task automatic run4(input int id, input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] es, input logic ec, input string tag);
    int   k;
    logic seen;
    @(negedge clk);
    if (id == 0) begin a0 = a; b0 = b; cin0 = ci; end
    else         begin a1 = a; b1 = b; cin1 = ci; end
    req[id] = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) chk({tag, "_gnt"}, gnt, (id == 0) ? 32'd1 : 32'd2);
      if (done) seen = 1'b1;
    end
    req[id] = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, k + 1, 7);
    chk({tag, "_done_id"}, done_id, id);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {busy, done}, 0);
  endtask

  initial begin
    int   k;
    logic seen;
    logic exp_id;

    rst_n = 1'b0;
    req = 2'b00; a0 = 4'h0; b0 = 4'h0; cin0 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
    req8 = 2'b00; a0_8 = 8'h0; b0_8 = 8'h0; cin0_8 = 1'b0; a1_8 = 8'h0; b1_8 = 8'h0; cin1_8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs4", {gnt, busy, done, done_id, sum, cout}, 0);
    chk("rst_outputs8", {gnt8, busy8, done8, done_id8, sum8, cout8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run4(0, 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, "r0_5p3");
    run4(1, 4'hF, 4'h1, 1'b1, 4'h1, 1'b1, "r1_Fp1c");
    run4(0, 4'hA, 4'h7, 1'b1, 4'h2, 1'b1, "r0_Ap7c");

    // Reset before the round-robin run so requester 0 wins first.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = 4'h3; b0 = 4'h4; cin0 = 1'b0;
    a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1;
    req = 2'b11;
    exp_id = 1'b0;
    for (int n = 0; n < 4; n++) begin
      k = 0;
      seen = 1'b0;
      while (!seen && k < 30) begin
        @(posedge clk); #1;
        k++;
        if (gnt != 2'b00 && gnt != 2'b01 && gnt != 2'b10) chk("rr_gnt_onehot", gnt, 1);
        if (done) seen = 1'b1;
      end
      chk("rr_done_seen", seen, 1);
      chk("rr_done_id", done_id, exp_id);
      chk("rr_sum", {cout, sum}, exp_id ? 32'h12 : 32'h07);
      exp_id = ~exp_id;
    end
    req = 2'b00;
    @(posedge clk); #1;
    chk("rr_idle", busy, 0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    a0 = 4'h2; b0 = 4'h2; cin0 = 1'b0;
    req = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk("mid_rst_outputs", {gnt, busy, done, done_id, sum, cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("mid_rst_no_restart", seen, 0);
    run4(0, 4'h6, 4'h9, 1'b0, 4'hF, 1'b0, "post_rst");

    // Requester drops req and changes operands after LOAD.
    @(negedge clk);
    a0 = 4'h6; b0 = 4'h7; cin0 = 1'b1;
    req = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req = 2'b00;
    a0 = 4'hF; b0 = 4'hF; cin0 = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1'b1;
    end
    chk("drop_done_seen", seen, 1);
    chk("drop_sum", {cout, sum}, 32'h0E);
    chk("drop_done_id", done_id, 0);

    // WIDTH=8 worst-case carry chain.
    @(negedge clk);
    a0_8 = 8'hFF; b0_8 = 8'hFF; cin0_8 = 1'b1;
    req8 = 2'b01;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) chk("w8_gnt", gnt8, 1);
      if (done8) seen = 1'b1;
    end
    req8 = 2'b00;
    chk("w8_done_seen", seen, 1);
    chk("w8_latency", k + 1, 11);
    chk("w8_sum", sum8, 8'hFF);
    chk("w8_cout", cout8, 1);
    chk("w8_done_id", done_id8, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
